// File: rtl/vga_pixel_write_arbiter.sv
// vga_pixel_write_arbiter: shares the VGA write port between an HPS PIO FIFO, an FPGA requester and a clear sweep
module vga_pixel_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int C_W = 3
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           vga_resolution_mode,
  input  logic           hps_write_en,
  input  logic [X_W-1:0] hps_x,
  input  logic [Y_W-1:0] hps_y,
  input  logic [C_W-1:0] hps_colour,
  input  logic           fpga_valid,
  output logic           fpga_ready,
  input  logic [X_W-1:0] fpga_x,
  input  logic [Y_W-1:0] fpga_y,
  input  logic [C_W-1:0] fpga_colour,
  input  logic           clear_start,
  input  logic [C_W-1:0] clear_colour,
  output logic           clear_busy,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           hps_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int E_W = X_W + Y_W + C_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [E_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic we_prev_q, hps_last_q, hps_last_d, ovf_q, ovf_d, plot_q, plot_d;
  logic c_mode_q, c_mode_d;
  logic [C_W-1:0] c_colour_q, c_colour_d, colour_q, colour_d, h_c, g_c;
  logic [X_W-1:0] cx_q, cx_d, x_q, x_d, h_x, g_x, cw_max, w_lim;
  logic [Y_W-1:0] cy_q, cy_d, y_q, y_d, h_y, g_y, ch_max, h_lim;
  logic idle, push, full, push_ok, grant_hps, grant_fpga, row_end, last_px;
  assign {h_x, h_y, h_c} = mem_q[rd_q];
  assign idle = state_q == IDLE;
  assign push = hps_write_en & ~we_prev_q;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign grant_hps = idle & (cnt_q != '0) & (~fpga_valid | ~hps_last_q);
  assign grant_fpga = idle & fpga_valid & ((cnt_q == '0) | hps_last_q);
  assign push_ok = push & (~full | grant_hps);
  assign fpga_ready = grant_fpga & resetn;
  assign clear_busy = ~idle;
  assign {x, y, colour, plot, hps_overflow} = {x_q, y_q, colour_q, plot_q, ovf_q};
  always_comb begin
    rd_d = rd_q + AW'(grant_hps);
    wr_d = wr_q + AW'(push_ok);
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(grant_hps);
    ovf_d = ovf_q | (push & full & ~grant_hps);
    hps_last_d = grant_hps ? 1'b1 : grant_fpga ? 1'b0 : hps_last_q;
    cw_max = c_mode_q ? X_W'(319) : X_W'(159);
    ch_max = c_mode_q ? Y_W'(239) : Y_W'(119);
    row_end = cx_q == cw_max;
    last_px = row_end & (cy_q == ch_max);
    state_d = idle ? (clear_start ? CLEAR : IDLE) : (last_px ? IDLE : CLEAR);
    cx_d = (idle | row_end) ? '0 : cx_q + 1'b1;
    cy_d = idle ? '0 : cy_q + Y_W'(row_end);
    c_colour_d = (idle & clear_start) ? clear_colour : c_colour_q;
    c_mode_d = (idle & clear_start) ? vga_resolution_mode : c_mode_q;
    g_x = !idle ? cx_q : grant_hps ? h_x : fpga_x;
    g_y = !idle ? cy_q : grant_hps ? h_y : fpga_y;
    g_c = !idle ? c_colour_q : grant_hps ? h_c : fpga_colour;
    w_lim = vga_resolution_mode ? X_W'(320) : X_W'(160);
    h_lim = vga_resolution_mode ? Y_W'(240) : Y_W'(120);
    plot_d = !idle | ((grant_hps | grant_fpga) & (g_x < w_lim) & (g_y < h_lim));
    x_d = plot_d ? g_x : x_q;
    y_d = plot_d ? g_y : y_q;
    colour_d = plot_d ? g_c : colour_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem_q[wr_q] <= {hps_x, hps_y, hps_colour};
  end
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      we_prev_q <= 1'b0;
      hps_last_q <= 1'b0;
      ovf_q <= 1'b0;
      plot_q <= 1'b0;
      c_mode_q <= 1'b0;
      c_colour_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      we_prev_q <= hps_write_en;
      hps_last_q <= hps_last_d;
      ovf_q <= ovf_d;
      plot_q <= plot_d;
      c_mode_q <= c_mode_d;
      c_colour_q <= c_colour_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
    end
  end
endmodule

// File: tb/tb_vga_pixel_write_arbiter.sv
// tb_vga_pixel_write_arbiter: directed vector table plus sweep, overflow and mid-sweep reset sequences
module tb_vga_pixel_write_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn, md, we, fv, rdy, cs, busy, plot, ovf;
  logic [8:0] hx, fx, x;
  logic [7:0] hy, fy, y;
  logic [2:0] hc, fc, cc, col;
  int n_cmp = 0;
  int n_bad = 0;
  vga_pixel_write_arbiter dut (
    .CLOCK_50(clk), .resetn(resetn), .vga_resolution_mode(md),
    .hps_write_en(we), .hps_x(hx), .hps_y(hy), .hps_colour(hc),
    .fpga_valid(fv), .fpga_ready(rdy), .fpga_x(fx), .fpga_y(fy), .fpga_colour(fc),
    .clear_start(cs), .clear_colour(cc), .clear_busy(busy),
    .x(x), .y(y), .colour(col), .plot(plot), .hps_overflow(ovf)
  );
  typedef struct {
    logic rn, md, we;
    logic [8:0] hx;
    logic [7:0] hy;
    logic [2:0] hc;
    logic fv;
    logic [8:0] fx;
    logic [7:0] fy;
    logic [2:0] fc;
    logic rdy, pl;
    logic [8:0] ex;
    logic [7:0] ey;
    logic [2:0] ec;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(int rn, int md_, int we_, int hx_, int hy_, int hc_, int fv_, int fx_, int fy_, int fc_,
                              int rdy_, int pl_, int ex_, int ey_, int ec_);
    vec_t v;
    v.rn = 1'(rn); v.md = 1'(md_); v.we = 1'(we_);
    v.hx = 9'(hx_); v.hy = 8'(hy_); v.hc = 3'(hc_);
    v.fv = 1'(fv_); v.fx = 9'(fx_); v.fy = 8'(fy_); v.fc = 3'(fc_);
    v.rdy = 1'(rdy_); v.pl = 1'(pl_); v.ex = 9'(ex_); v.ey = 8'(ey_); v.ec = 3'(ec_);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask
  task automatic idle_inputs();
    we = 0; hx = 0; hy = 0; hc = 0; fv = 0; fx = 0; fy = 0; fc = 0; cs = 0; cc = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    idle_inputs();
    @(negedge clk);
    resetn = 1;
  endtask
  initial begin
    int plot_n, busy_n, bad_px, bad_rdy, k;
    logic done;
    logic [19:0] exp_px;
    resetn = 0; md = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    //        rn md we  hx  hy hc  fv  fx  fy fc   rdy pl  ex  ey ec
    vq.push_back(mk(0, 0, 0,   0,  0, 0,  0,   0,  0, 0,  0, 0,   0,  0, 0));
    vq.push_back(mk(1, 0, 1,   5,  7, 5,  0,   0,  0, 0,  0, 0,   0,  0, 0));
    vq.push_back(mk(1, 0, 1,   5,  7, 5,  0,   0,  0, 0,  0, 0,   0,  0, 0));
    vq.push_back(mk(1, 0, 1,   5,  7, 5,  0,   0,  0, 0,  0, 1,   5,  7, 5));
    vq.push_back(mk(1, 0, 1,   5,  7, 5,  0,   0,  0, 0,  0, 0,   5,  7, 5));
    vq.push_back(mk(1, 0, 0,   5,  7, 5,  0,   0,  0, 0,  0, 0,   5,  7, 5));
    vq.push_back(mk(0, 0, 0,   0,  0, 0,  0,   0,  0, 0,  0, 0,   5,  7, 5));
    vq.push_back(mk(1, 0, 1,   1,  1, 1,  0,   0,  0, 0,  0, 0,   0,  0, 0));
    vq.push_back(mk(1, 0, 0,   1,  1, 1,  1,   2,  2, 2,  0, 0,   0,  0, 0));
    vq.push_back(mk(1, 0, 1,   3,  3, 3,  1,   2,  2, 2,  1, 1,   1,  1, 1));
    vq.push_back(mk(1, 0, 0,   3,  3, 3,  1,   2,  2, 2,  0, 1,   2,  2, 2));
    vq.push_back(mk(1, 0, 1,   4,  4, 4,  1,   2,  2, 2,  1, 1,   3,  3, 3));
    vq.push_back(mk(1, 0, 0,   4,  4, 4,  1,   2,  2, 2,  0, 1,   2,  2, 2));
    vq.push_back(mk(1, 0, 0,   4,  4, 4,  0,   2,  2, 2,  0, 1,   4,  4, 4));
    vq.push_back(mk(1, 0, 0,   4,  4, 4,  0,   2,  2, 2,  0, 0,   4,  4, 4));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  1, 200, 50, 3,  1, 0,   4,  4, 4));
    vq.push_back(mk(1, 1, 0,   0,  0, 0,  0, 200, 50, 3,  0, 0,   4,  4, 4));
    vq.push_back(mk(1, 1, 0,   0,  0, 0,  1, 200, 50, 3,  1, 0,   4,  4, 4));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  0,   0,  0, 0,  0, 1, 200, 50, 3));
    vq.push_back(mk(1, 0, 1, 170, 10, 1,  0,   0,  0, 0,  0, 0, 200, 50, 3));
    vq.push_back(mk(1, 0, 0, 170, 10, 1,  0,   0,  0, 0,  0, 0, 200, 50, 3));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  0,   0,  0, 0,  0, 0, 200, 50, 3));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  1,   1,  2, 3,  1, 0, 200, 50, 3));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  0,   0,  0, 0,  0, 1,   1,  2, 3));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  1, 159,120, 7,  1, 0,   1,  2, 3));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  1, 159,119, 7,  1, 0,   1,  2, 3));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  0,   0,  0, 0,  0, 1, 159,119, 7));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  1, 160,119, 7,  1, 0, 159,119, 7));
    vq.push_back(mk(1, 0, 0,   0,  0, 0,  0,   0,  0, 0,  0, 0, 159,119, 7));
    foreach (vq[i]) begin
      @(negedge clk);
      resetn = vq[i].rn; md = vq[i].md; we = vq[i].we;
      hx = vq[i].hx; hy = vq[i].hy; hc = vq[i].hc;
      fv = vq[i].fv; fx = vq[i].fx; fy = vq[i].fy; fc = vq[i].fc;
      #1;
      chk($sformatf("vec%0d", i), {rdy, plot, x, y, col, busy, ovf},
          {vq[i].rdy, vq[i].pl, vq[i].ex, vq[i].ey, vq[i].ec, 1'b0, 1'b0});
    end
    // 160x120 sweep with HPS pushes piling up behind it, then the backlog drains against the FPGA
    do_reset();
    md = 0; cs = 1; cc = 3'd2;
    plot_n = 0; busy_n = 0; bad_px = 0; bad_rdy = 0;
    for (int c = 0; c <= 19212; c++) begin
      @(negedge clk);
      cs = (c == 50);
      cc = (c == 50) ? 3'd7 : 3'd2;
      md = (c >= 100 && c < 5000);
      fv = 1; fx = 150; fy = 100; fc = 6;
      we = (c >= 2 && c <= 10 && c % 2 == 0);
      hx = 9'(10 + (c - 2) / 2); hy = 8'(20 + (c - 2) / 2); hc = 3'((c - 2) / 2);
      #1;
      if (busy) begin
        busy_n++;
        if (rdy) bad_rdy++;
      end
      if (c >= 19200 && c < 19208) chk($sformatf("post_rdy%0d", c - 19200), rdy, 64'((c - 19200) % 2));
      if (c == 10) chk("ovf_before", ovf, 0);
      if (c == 12) chk("ovf_set", ovf, 1);
      if (c == 19200) chk("ovf_sticky", ovf, 1);
      if (plot) begin
        if (plot_n < 19200) begin
          exp_px = {9'(plot_n % 160), 8'(plot_n / 160), 3'd2};
          if ({x, y, col} != exp_px) bad_px++;
          if (plot_n == 0 || plot_n == 159 || plot_n == 160 || plot_n == 19199)
            chk($sformatf("sweep_px%0d", plot_n), {x, y, col}, exp_px);
        end else begin
          k = plot_n - 19200;
          exp_px = (k % 2 == 1 || k >= 8) ? {9'd150, 8'd100, 3'd6} : {9'(10 + k / 2), 8'(20 + k / 2), 3'(k / 2)};
          chk($sformatf("post_px%0d", k), {x, y, col}, exp_px);
        end
        plot_n++;
      end
    end
    chk("sweep_busy_cycles", busy_n, 19200);
    chk("sweep_plot_total", plot_n, 19212);
    chk("sweep_bad_pixels", bad_px, 0);
    chk("ready_in_clear", bad_rdy, 0);
    // 320x240 sweep interrupted by reset at pixel 1000
    do_reset();
    md = 1; cs = 1; cc = 3'd5;
    plot_n = 0; done = 0;
    for (int c = 0; c < 1100 && !done; c++) begin
      @(negedge clk);
      cs = 0; md = 1;
      we = (c == 2); hx = 9; hy = 9; hc = 1;
      if (plot) begin
        exp_px = {9'(plot_n % 320), 8'(plot_n / 320), 3'd5};
        if (plot_n == 319 || plot_n == 320 || plot_n == 1000)
          chk($sformatf("wide_px%0d", plot_n), {x, y, col}, exp_px);
        if (plot_n == 1000) begin
          resetn = 0;
          done = 1;
        end
        plot_n++;
      end
    end
    chk("reach_px1000", done, 1);
    @(negedge clk);
    we = 0;
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pixel", {x, y, col, ovf}, 0);
    resetn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_fifo_empty%0d", i), plot, 0);
    end
    @(negedge clk);
    we = 1; hx = 7; hy = 8; hc = 4;
    @(negedge clk);
    we = 0;
    chk("new_edge_wait", plot, 0);
    @(negedge clk);
    chk("new_edge_plot", {plot, x, y, col}, {1'b1, 9'd7, 8'd8, 3'd4});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_pixel_write_arbiter.md
Name: vga_pixel_write_arbiter

Overview:
Shares the single VGA framebuffer write port between three sources and issues at most one pixel write per clock. The sources are the HPS PIO pixel word, an FPGA-side valid/ready requester, and a built-in clear-screen sweep engine. It sits between the HPS vga_user PIO fields / fpga_portion drawing logic and the VGA adapter's x/y/colour/plot inputs. It converts the level-style PIO writeEn into single buffered write requests.

Parameters:
FIFO_DEPTH, 4, HPS request FIFO entries (power of 2, >=2)
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
C_W, 3, colour width

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  synchronous active-low reset
vga_resolution_mode  in  1  0 = 160x120, 1 = 320x240
hps_write_en  in  1  PIO writeEn level; each 0->1 edge is one request
hps_x  in  X_W  PIO x
hps_y  in  Y_W  PIO y
hps_colour  in  C_W  PIO colour
fpga_valid  in  1  FPGA requester has a pixel
fpga_ready  out  1  FPGA pixel accepted this cycle (valid & ready)
fpga_x  in  X_W  FPGA x
fpga_y  in  Y_W  FPGA y
fpga_colour  in  C_W  FPGA colour
clear_start  in  1  one-cycle pulse; starts a full-screen fill
clear_colour  in  C_W  fill colour, sampled with clear_start
clear_busy  out  1  sweep in progress
x  out  X_W  pixel x to VGA adapter
y  out  Y_W  pixel y to VGA adapter
colour  out  C_W  pixel colour to VGA adapter
plot  out  1  write strobe, one cycle per pixel
hps_overflow  out  1  sticky: an HPS request was dropped

Behaviour:
- Reset (resetn=0 at a CLOCK_50 edge): plot=0, x=y=colour=0, clear_busy=0, hps_overflow=0, FIFO empty, edge register=0, round-robin pointer = "FPGA last", state IDLE. fpga_ready=0 while resetn=0. Reset mid-sweep or mid-FIFO discards all pending work.
- HPS capture: register hps_write_en each cycle. On rising edge (current=1, previous=0), push {hps_x,hps_y,hps_colour} from that same cycle.
  - Full FIFO: drop the request and set hps_overflow until reset.
  - Full FIFO with a pop in the same cycle: push succeeds.
  - Holding writeEn high gives exactly one request.
- States: IDLE, CLEAR.
  - IDLE->CLEAR on clear_start. Latch clear_colour and vga_resolution_mode. Counters cx=cy=0.
  - CLEAR: emit one pixel per cycle, x inner, y outer: (0,0),(1,0)...(W-1,0),(0,1)...(W-1,H-1). W,H = 160,120 or 320,240 from the latched mode.
  - After the (W-1,H-1) grant, return to IDLE. The sweep is exactly W*H grant cycles: 19200 or 76800.
  - clear_busy=1 in every CLEAR cycle.
  - clear_start while in CLEAR is ignored. Mode changes mid-sweep are ignored.
- Arbitration (IDLE only), one grant per cycle:
  - Candidates: HPS (FIFO non-empty) and FPGA (fpga_valid).
  - Single candidate wins.
  - Both present: round-robin; the source not granted last wins. After reset, HPS wins the first tie.
  - Pointer updates only on an actual grant.
  - fpga_ready is combinational = FPGA granted this cycle. It is 0 in CLEAR.
  - HPS FIFO pops on HPS grant.
  - In CLEAR, the FIFO still accepts pushes but never pops.
- Output: registered. A pixel granted in cycle N drives x/y/colour with plot=1 in cycle N+1. With no grant, plot=0 and x/y/colour hold their last values.
- Range check on HPS/FPGA grants against the current vga_resolution_mode: x>=W or y>=H is consumed (pop / ready asserted, pointer updated) but plot stays 0. Clear pixels are always in range.
- Throughput: back-to-back grants give continuous plot=1.

Test Plan:
1. Reset, then hps_write_en held high 10 cycles with (5,7,3'b101) -> exactly one plot two cycles after the edge, x=5 y=7 colour=5. hps_overflow=0.
2. Five HPS edges with FPGA idle and fpga_valid low for 4 cycles after the edges (FIFO_DEPTH=4), sustained fill -> FIFO drains in order. Fill with no pops: the 5th request is dropped and hps_overflow=1 and stays 1.
3. FIFO non-empty and fpga_valid=1 continuously -> grants alternate HPS,FPGA,HPS... starting with HPS after reset. fpga_ready pulses every other cycle.
4. mode=0, clear_start with clear_colour=3'b010 -> clear_busy high 19200 cycles. plot outputs (0,0) first, (159,0) then (0,1), (159,119) last, all colour 2. fpga_ready=0 throughout. mode=1 -> 76800 cycles ending (319,239).
5. mode=0, FPGA pixel (200,50) -> fpga_ready=1, no plot. Same pixel with mode=1 -> plotted.
6. resetn low mid-sweep at pixel 1000 -> next cycle plot=0, clear_busy=0. After release, FIFO empty and a new HPS edge is serviced normally.
